// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stage_ctrl
//  Description : Multi-cycle stage sequencer for the sequential Y86-64 core.
//                Steps fetch/decode/execute/memory/writeback/PC-update, owns
//                the architectural PC, drives memory requests and CC/RF write
//                enables, and reports the Y86 status code.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl #(
   parameter int                ADDR_W      = 64,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                MEM_TIMEOUT = 16,
   parameter int                CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic              instr_valid,
   input  logic              imem_error,
   input  logic              dmem_error,
   input  logic              mem_ack,
   input  logic [ADDR_W-1:0] updated_pc,
   output logic [ADDR_W-1:0] pc,
   output logic [5:0]        stage,
   output logic              imem_req,
   output logic              dmem_req,
   output logic              cc_we,
   output logic              rf_we,
   output logic [2:0]        stat,
   output logic              busy,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int                 c_TMO_W    = $clog2(MEM_TIMEOUT);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(MEM_TIMEOUT - 1);

   localparam logic [2:0] c_STAT_AOK = 3'd1;
   localparam logic [2:0] c_STAT_HLT = 3'd2;
   localparam logic [2:0] c_STAT_ADR = 3'd3;
   localparam logic [2:0] c_STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_PCUPD     = 3'd6,
      ST_HALTED    = 3'd7
   } state_t;

   state_t             r_state;
   state_t             w_nxt;
   logic [2:0]         w_stat_nxt;
   logic [3:0]         r_icode;
   logic [c_TMO_W-1:0] r_tmo;
   logic               w_tmo_hit;
   logic               w_mem_op;
   logic               w_rf_op;
   logic               w_stopped;
   logic               w_waiting;

   // One-hot stage vector {P,W,M,E,D,F} for a given state
   function automatic logic [5:0] f_stage(input state_t s);
      logic [5:0] v;
      v = 6'b000000;
      case (s)
         ST_FETCH:     v = 6'b000001;
         ST_DECODE:    v = 6'b000010;
         ST_EXECUTE:   v = 6'b000100;
         ST_MEMORY:    v = 6'b001000;
         ST_WRITEBACK: v = 6'b010000;
         ST_PCUPD:     v = 6'b100000;
         default:      v = 6'b000000;
      endcase
      return v;
   endfunction

   // Instruction class decode on the latched icode and timeout detection
   always_comb begin
      w_mem_op  = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      w_rf_op   = r_icode inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
      w_tmo_hit = (r_tmo == c_TMO_LAST);
      w_stopped = (r_state == ST_IDLE) || (r_state == ST_HALTED);
      w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
   end

   // Next-state and next-status selection; fetch faults follow a fixed priority
   always_comb begin
      w_nxt      = r_state;
      w_stat_nxt = stat;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               w_nxt      = ST_FETCH;
               w_stat_nxt = c_STAT_AOK;
            end
         end
         ST_FETCH: begin
            if (mem_ack) begin
               if (imem_error) begin
                  w_nxt      = ST_HALTED;
                  w_stat_nxt = c_STAT_ADR;
               end else if (!instr_valid) begin
                  w_nxt      = ST_HALTED;
                  w_stat_nxt = c_STAT_INS;
               end else if (icode == 4'h0) begin
                  w_nxt      = ST_HALTED;
                  w_stat_nxt = c_STAT_HLT;
               end else begin
                  w_nxt = ST_DECODE;
               end
            end else if (w_tmo_hit) begin
               w_nxt      = ST_HALTED;
               w_stat_nxt = c_STAT_ADR;
            end
         end
         ST_DECODE:  w_nxt = ST_EXECUTE;
         ST_EXECUTE: w_nxt = w_mem_op ? ST_MEMORY : ST_WRITEBACK;
         ST_MEMORY: begin
            if (mem_ack) begin
               if (dmem_error) begin
                  w_nxt      = ST_HALTED;
                  w_stat_nxt = c_STAT_ADR;
               end else begin
                  w_nxt = ST_WRITEBACK;
               end
            end else if (w_tmo_hit) begin
               w_nxt      = ST_HALTED;
               w_stat_nxt = c_STAT_ADR;
            end
         end
         ST_WRITEBACK: w_nxt = ST_PCUPD;
         ST_PCUPD:     w_nxt = ST_FETCH;
         default:      w_nxt = ST_IDLE;
      endcase
   end

   // State register with outputs registered from the next state (Moore timing)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_icode     <= 4'h0;
         r_tmo       <= '0;
         pc          <= RESET_PC;
         stat        <= c_STAT_AOK;
         instr_count <= '0;
         stage       <= 6'b000000;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         cc_we       <= 1'b0;
         rf_we       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         stat     <= w_stat_nxt;
         stage    <= f_stage(w_nxt);
         imem_req <= (w_nxt == ST_FETCH);
         dmem_req <= (w_nxt == ST_MEMORY);
         // r_icode is already latched by the time EXECUTE/WRITEBACK are entered
         cc_we    <= (w_nxt == ST_EXECUTE) && (r_icode == 4'h6);
         rf_we    <= (w_nxt == ST_WRITEBACK) && w_rf_op;
         busy     <= (w_nxt != ST_IDLE) && (w_nxt != ST_HALTED);

         if ((r_state == ST_FETCH) && mem_ack) begin
            r_icode <= icode;
         end

         // Wait counter restarts on every state change, counts unacked cycles
         if (w_nxt != r_state) begin
            r_tmo <= '0;
         end else if (w_waiting && !mem_ack) begin
            r_tmo <= r_tmo + 1'b1;
         end

         if (w_stopped && start) begin
            pc          <= RESET_PC;
            instr_count <= '0;
         end else if (r_state == ST_PCUPD) begin
            pc          <= updated_pc;
            instr_count <= instr_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
